// File: rtl/gpu_regs_timing.sv
// LCD register file and scanline timing: dot/line counters, STAT mode
// derivation, LY=LYC compare, and VBlank / STAT / DMA-start pulses.
module gpu_regs_timing #(
  parameter int DOTS_OAM    = 80,
  parameter int DOTS_XFER   = 172,
  parameter int DOTS_LINE   = 456,
  parameter int LINES_VIS   = 144,
  parameter int LINES_TOTAL = 154
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iDotTick,
  input  logic [3:0] iRegSelect,
  input  logic       iRegWe,
  input  logic [7:0] iRegData,
  output logic [7:0] oLCDC,
  output logic [7:0] oSTAT,
  output logic [7:0] oSCY,
  output logic [7:0] oSCX,
  output logic [7:0] oLY,
  output logic [7:0] oLYC,
  output logic [7:0] oDMA,
  output logic [7:0] oBGP,
  output logic [7:0] oOBP0,
  output logic [7:0] oOBP1,
  output logic [7:0] oWY,
  output logic [7:0] oWX,
  output logic [8:0] oDotCount,
  output logic       oIntVBlank,
  output logic       oIntStat,
  output logic       oDmaStart
);

  localparam logic [3:0] R_LCDC = 4'd0, R_STAT = 4'd1, R_SCY  = 4'd2,  R_SCX = 4'd3,
                         R_LY   = 4'd4, R_LYC  = 4'd5, R_DMA  = 4'd6,  R_BGP = 4'd7,
                         R_OBP0 = 4'd8, R_OBP1 = 4'd9, R_WY   = 4'd10, R_WX  = 4'd11;

  localparam logic [8:0] DOT_OAM_END  = 9'(DOTS_OAM);
  localparam logic [8:0] DOT_XFER_END = 9'(DOTS_OAM + DOTS_XFER);
  localparam logic [8:0] DOT_LAST     = 9'(DOTS_LINE - 1);
  localparam logic [7:0] LY_VIS       = 8'(LINES_VIS);
  localparam logic [7:0] LY_VIS_PRE   = 8'(LINES_VIS - 1);
  localparam logic [7:0] LY_LAST      = 8'(LINES_TOTAL - 1);

  logic [7:0] lcdc, scy, scx, ly, lyc, dma, bgp, obp0, obp1, wy, wx;
  logic [3:0] stat_en;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       lyc_eq, stat_src, stat_src_q;
  logic       int_vblank, int_stat, dma_start;
  logic       ly_wr, lcd_on_next;

  assign ly_wr       = iRegWe && (iRegSelect == R_LY);
  // Counters clear on the same edge that turns the LCD off.
  assign lcd_on_next = (iRegWe && iRegSelect == R_LCDC) ? iRegData[7] : lcdc[7];

  always_comb begin
    mode = 2'd0;
    if (lcdc[7]) begin
      if (ly >= LY_VIS)           mode = 2'd1;
      else if (dot < DOT_OAM_END)  mode = 2'd2;
      else if (dot < DOT_XFER_END) mode = 2'd3;
      else                         mode = 2'd0;
    end
  end

  assign lyc_eq   = (ly == lyc);
  assign stat_src = (stat_en[3] & lyc_eq) | (stat_en[2] & (mode == 2'd2)) |
                    (stat_en[1] & (mode == 2'd1)) | (stat_en[0] & (mode == 2'd0));

  always_ff @(posedge iClock) begin
    if (iReset) begin
      lcdc       <= 8'h91;
      stat_en    <= 4'h0;
      scy        <= 8'h00;
      scx        <= 8'h00;
      ly         <= 8'h00;
      lyc        <= 8'h00;
      dma        <= 8'h00;
      bgp        <= 8'hFC;
      obp0       <= 8'hFF;
      obp1       <= 8'hFF;
      wy         <= 8'h00;
      wx         <= 8'h00;
      dot        <= 9'd0;
      stat_src_q <= 1'b0;
      int_vblank <= 1'b0;
      int_stat   <= 1'b0;
      dma_start  <= 1'b0;
    end else begin
      stat_src_q <= stat_src;
      int_stat   <= stat_src & ~stat_src_q;
      dma_start  <= iRegWe && (iRegSelect == R_DMA);
      int_vblank <= 1'b0;

      if (iRegWe) begin
        case (iRegSelect)
          R_LCDC:  lcdc    <= iRegData;
          R_STAT:  stat_en <= iRegData[6:3];
          R_SCY:   scy     <= iRegData;
          R_SCX:   scx     <= iRegData;
          R_LYC:   lyc     <= iRegData;
          R_DMA:   dma     <= iRegData;
          R_BGP:   bgp     <= iRegData;
          R_OBP0:  obp0    <= iRegData;
          R_OBP1:  obp1    <= iRegData;
          R_WY:    wy      <= iRegData;
          R_WX:    wx      <= iRegData;
          default: ;
        endcase
      end

      if (ly_wr || !lcd_on_next) begin
        dot <= 9'd0;
        ly  <= 8'd0;
      end else if (lcdc[7] && iDotTick) begin
        if (dot == DOT_LAST) begin
          dot        <= 9'd0;
          ly         <= (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
          int_vblank <= (ly == LY_VIS_PRE);
        end else begin
          dot <= dot + 9'd1;
        end
      end
    end
  end

  assign oLCDC      = lcdc;
  assign oSTAT      = {1'b1, stat_en, lyc_eq, mode};
  assign oSCY       = scy;
  assign oSCX       = scx;
  assign oLY        = ly;
  assign oLYC       = lyc;
  assign oDMA       = dma;
  assign oBGP       = bgp;
  assign oOBP0      = obp0;
  assign oOBP1      = obp1;
  assign oWY        = wy;
  assign oWX        = wx;
  assign oDotCount  = dot;
  assign oIntVBlank = int_vblank;
  assign oIntStat   = int_stat;
  assign oDmaStart  = dma_start;

endmodule

// File: tb/tb_gpu_regs_timing.sv
// Scoreboard bench for gpu_regs_timing: directed stimulus queues expected
// values; a negedge monitor pops and compares. A second instance takes a mid-frame reset.
module tb_gpu_regs_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, tick, we;
  logic [3:0] sel;
  logic [7:0] data;

  logic [7:0] a_reg [12];
  logic [7:0] b_reg [12];
  logic [8:0] a_dot, b_dot;
  logic       a_vb, a_st, a_dma, b_vb, b_st, b_dma;

  gpu_regs_timing u_dut (
    .iClock(clk), .iReset(rst_a), .iDotTick(tick), .iRegSelect(sel), .iRegWe(we), .iRegData(data),
    .oLCDC(a_reg[0]), .oSTAT(a_reg[1]), .oSCY(a_reg[2]), .oSCX(a_reg[3]), .oLY(a_reg[4]),
    .oLYC(a_reg[5]), .oDMA(a_reg[6]), .oBGP(a_reg[7]), .oOBP0(a_reg[8]), .oOBP1(a_reg[9]),
    .oWY(a_reg[10]), .oWX(a_reg[11]), .oDotCount(a_dot),
    .oIntVBlank(a_vb), .oIntStat(a_st), .oDmaStart(a_dma)
  );

  gpu_regs_timing u_rst (
    .iClock(clk), .iReset(rst_b), .iDotTick(tick), .iRegSelect(sel), .iRegWe(we), .iRegData(data),
    .oLCDC(b_reg[0]), .oSTAT(b_reg[1]), .oSCY(b_reg[2]), .oSCX(b_reg[3]), .oLY(b_reg[4]),
    .oLYC(b_reg[5]), .oDMA(b_reg[6]), .oBGP(b_reg[7]), .oOBP0(b_reg[8]), .oOBP1(b_reg[9]),
    .oWY(b_reg[10]), .oWX(b_reg[11]), .oDotCount(b_dot),
    .oIntVBlank(b_vb), .oIntStat(b_st), .oDmaStart(b_dma)
  );

  // Signal ids: 0..11 regs of A, 12 dot, 13..15 pulses, 16..19 pulse stats, 20+ instance B.
  localparam int LCDC = 0, STAT = 1, SCY = 2, SCX = 3, LY = 4, LYC = 5, DMA = 6, BGP = 7,
                 OBP0 = 8, OBP1 = 9, WY = 10, WX = 11, DOT = 12, VB = 13, ST = 14, DS = 15,
                 VB_CNT = 16, ST_CNT = 17, DS_CNT = 18, LONG = 19, B_OFS = 20;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_vec = 0, n_bad = 0;
  int   vb_cnt = 0, st_cnt = 0, ds_cnt = 0;
  logic long_pulse = 1'b0, prev_vb = 1'b0, prev_st = 1'b0, prev_ds = 1'b0;

  logic [7:0] rst_vals [12] = '{8'h91, 8'h86, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'hFC, 8'hFF, 8'hFF, 8'h00, 8'h00};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] get_sig(int s);
    if (s < 12) return {24'h0, a_reg[s]};
    if (s >= B_OFS && s < B_OFS + 12) return {24'h0, b_reg[s - B_OFS]};
    case (s)
      DOT:          return {23'h0, a_dot};
      VB:           return {31'h0, a_vb};
      ST:           return {31'h0, a_st};
      DS:           return {31'h0, a_dma};
      VB_CNT:       return vb_cnt;
      ST_CNT:       return st_cnt;
      DS_CNT:       return ds_cnt;
      LONG:         return {31'h0, long_pulse};
      B_OFS + DOT:  return {23'h0, b_dot};
      B_OFS + VB:   return {31'h0, b_vb};
      B_OFS + ST:   return {31'h0, b_st};
      B_OFS + DS:   return {31'h0, b_dma};
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    if (a_vb === 1'b1) begin vb_cnt++; if (prev_vb) long_pulse = 1'b1; end
    if (a_st === 1'b1) begin st_cnt++; if (prev_st) long_pulse = 1'b1; end
    if (a_dma === 1'b1) begin ds_cnt++; if (prev_ds) long_pulse = 1'b1; end
    prev_vb = (a_vb === 1'b1);
    prev_st = (a_st === 1'b1);
    prev_ds = (a_dma === 1'b1);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      e   = exp_q.pop_front();
      act = get_sig(e.sig);
      n_vec++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0h, want %0h", e.name, act, e.val);
      end
    end
  end

  task automatic chk(int s, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wr(logic [3:0] s, logic [7:0] d);
    sel  = s;
    data = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; tick = 1'b0; we = 1'b0; sel = 4'd0; data = 8'h00;
    step();
    for (int i = 0; i < 12; i++) chk(i, {24'h0, rst_vals[i]}, $sformatf("reset_reg%0d", i));
    chk(DOT, 0, "reset_dot");
    chk(VB, 0, "reset_vblank");
    chk(ST, 0, "reset_intstat");
    chk(DS, 0, "reset_dmastart");
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Line 0 mode boundaries
    tick = 1'b1;
    run(40);  chk(STAT, 'h86, "stat_dot40");
    run(39);  chk(DOT, 79, "dot79"); chk(STAT, 'h86, "stat_dot79");
    run(1);   chk(STAT, 'h87, "stat_dot80_mode3");
    run(171); chk(STAT, 'h87, "stat_dot251_mode3");
    run(1);   chk(STAT, 'h84, "stat_dot252_mode0");
    run(203); chk(DOT, 455, "dot455"); chk(LY, 0, "ly_before_wrap");
    run(1);   chk(LY, 1, "ly1_after_wrap"); chk(DOT, 0, "dot_wrap"); chk(STAT, 'h82, "stat_line1_mode2");

    // LYC match interrupt on line 5; STAT write keeps only bits 6:3
    tick = 1'b0;
    wr(4'd5, 8'h05); chk(LYC, 'h05, "lyc_write");
    wr(4'd1, 8'h47); chk(STAT, 'hC2, "stat_write_masked");
    chk(ST_CNT, 0, "no_stat_pulse_yet");
    tick = 1'b1;
    run(4*456); chk(LY, 5, "ly5"); chk(STAT, 'hC6, "stat_ly5_mode2");
    run(1);     chk(ST, 1, "intstat_pulse"); chk(ST_CNT, 1, "intstat_once");
    run(79);    chk(STAT, 'hC7, "stat_ly5_mode3");
    run(172);   chk(STAT, 'hC4, "stat_ly5_mode0");
    run(203);   chk(ST_CNT, 1, "no_repulse_line5"); chk(ST, 0, "intstat_low");
    run(1);     chk(LY, 6, "ly6"); chk(STAT, 'hC2, "stat_ly6");

    // Mid-frame reset of instance B at line 100, with a dot tick in the same cycle
    run(94*456 + 200); chk(LY, 100, "ly100");
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 12; i++) chk(B_OFS + i, {24'h0, rst_vals[i]}, $sformatf("midreset_reg%0d", i));
    chk(B_OFS + DOT, 0, "midreset_dot");
    chk(B_OFS + VB, 0, "midreset_vblank");
    chk(B_OFS + ST, 0, "midreset_intstat");
    chk(B_OFS + DS, 0, "midreset_dmastart");
    chk(DOT, 201, "a_unaffected_by_b_reset");

    // VBlank entry and frame wrap
    run(43*456 + 254); chk(LY, 143, "ly143"); chk(DOT, 455, "ly143_dot455"); chk(VB_CNT, 0, "no_early_vblank");
    run(1); chk(LY, 144, "ly144"); chk(VB, 1, "vblank_pulse"); chk(STAT, 'hC1, "stat_vblank_mode1");
    run(1); chk(VB, 0, "vblank_one_cycle");
    run(10*456 - 1); chk(LY, 0, "frame_wrap_ly0"); chk(DOT, 0, "frame_wrap_dot0");
    chk(VB_CNT, 1, "single_vblank"); chk(STAT, 'hC2, "stat_frame2_start");

    // LCD disable mid-line, then re-enable
    run(10*456 + 100); chk(LY, 10, "ly10"); chk(ST_CNT, 2, "stat_pulse_frame2");
    wr(4'd0, 8'h11); chk(LCDC, 'h11, "lcdc_off"); chk(LY, 0, "off_ly0"); chk(DOT, 0, "off_dot0");
    chk(STAT, 'hC0, "off_stat_mode0");
    run(3); chk(DOT, 0, "off_dot_frozen");
    wr(4'd0, 8'h91); chk(LCDC, 'h91, "lcdc_on"); chk(DOT, 0, "on_dot0"); chk(STAT, 'hC2, "on_mode2");
    run(1); chk(DOT, 1, "on_counting");

    // DMA start pulse; LY write racing the dot wrap
    tick = 1'b0;
    wr(4'd6, 8'hC1); chk(DMA, 'hC1, "dma_value"); chk(DS, 1, "dma_start");
    step(); chk(DS, 0, "dma_start_one_cycle"); chk(DS_CNT, 1, "dma_single");
    tick = 1'b1;
    run(454); chk(DOT, 455, "pre_wrap_dot455");
    wr(4'd4, 8'h33); chk(LY, 0, "ly_write_wins_ly"); chk(DOT, 0, "ly_write_wins_dot");
    tick = 1'b0;

    // Out-of-range select is ignored; a few plain registers
    wr(4'd13, 8'hAA);
    chk(LCDC, 'h91, "ign_lcdc"); chk(STAT, 'hC2, "ign_stat"); chk(SCY, 'h00, "ign_scy");
    chk(SCX, 'h00, "ign_scx"); chk(LYC, 'h05, "ign_lyc"); chk(DMA, 'hC1, "ign_dma");
    chk(BGP, 'hFC, "ign_bgp"); chk(OBP0, 'hFF, "ign_obp0"); chk(OBP1, 'hFF, "ign_obp1");
    chk(WY, 'h00, "ign_wy"); chk(WX, 'h00, "ign_wx"); chk(DS, 0, "ign_no_dma_start");
    wr(4'd2, 8'h12);  chk(SCY, 'h12, "scy_write");
    wr(4'd11, 8'h34); chk(WX, 'h34, "wx_write");
    wr(4'd7, 8'hE4);  chk(BGP, 'hE4, "bgp_write");
    wr(4'd9, 8'h5A);  chk(OBP1, 'h5A, "obp1_write"); chk(OBP0, 'hFF, "obp0_untouched");
    step();
    chk(VB_CNT, 1, "total_vblank"); chk(ST_CNT, 2, "total_stat");
    chk(DS_CNT, 1, "total_dma"); chk(LONG, 0, "no_long_pulse");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
